booth_mac_accum: RTL
====================

Name: booth_mac_accum

Overview:
- Sequential stage directly downstream of the 4-bit Booth multiplier.
- Consumes the signed 8-bit product Z over a valid/ready handshake and accumulates successive products into a saturating signed accumulator.
- Closes a dot-product group on an explicit last flag or after MAX_TERMS products, then presents the group result on a registered valid/ready output.
- Feeds the result/display stage of the multiplier datapath.

Parameters:
- PROD_W, 8: product width; signed two's complement, matches Booth Z.
- ACC_W, 10: accumulator width, signed; range -512..511.
- MAX_TERMS, 16: maximum products per group before forced close.
- CNT_W, 5: term counter width; must satisfy 2**CNT_W > MAX_TERMS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous group abort; discards the current group.
- in_valid  input  1  product valid.
- in_ready  output  1  stage can accept a product.
- in_prod  input  PROD_W  signed product (Booth Z).
- in_last  input  1  final product of the group; qualified by handshake.
- out_valid  output  1  group result valid.
- out_ready  input  1  consumer accepts result.
- out_acc  output  ACC_W  signed accumulated result.
- out_cnt  output  CNT_W  number of products in the group.
- out_ovf  output  1  saturation occurred at least once in the group.

Behaviour:
- Reset (async, rst=1): state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_acc=0, out_cnt=0, out_ovf=0, in_ready=1 once rst deasserts.
- Reset mid-group discards the partial result immediately; no output is produced.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1, outputs held stable.
- Input handshake = in_valid & in_ready.
- On handshake in ACCUM:
  - acc <= sat(acc + sext(in_prod)); cnt <= cnt+1.
  - ovf <= ovf | (saturation this cycle).
- Saturation: compute in ACC_W+1 bits. Result > 2**(ACC_W-1)-1 clamps to max; result < -2**(ACC_W-1) clamps to min.
- Close condition: handshake with in_last=1, or handshake when cnt==MAX_TERMS-1.
  - On close, next cycle: state=DONE; out_acc, out_cnt and out_ovf hold the post-update values.
  - Latency is 1 clock from the closing handshake to out_valid.
- DONE with out_ready=1: next cycle state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0. A new product is accepted at the earliest one cycle later; there is no same-cycle bypass.
- DONE with out_ready=0: hold indefinitely; in_prod is ignored because in_ready=0.
- clear=1 (synchronous, any state):
  - Next cycle: state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0.
  - clear has priority over a simultaneous input handshake; that product is dropped.
  - clear has priority over out_ready.
- No empty groups: out_cnt is always >= 1 when out_valid=1.
- in_prod is sign-extended; the full 8-bit range is handled (Booth 4x4 produces -56..64).

Decomposition:
- Shared package/include booth_pkg:
  - PROD_W, ACC_W, MAX_TERMS, CNT_W defaults.
  - State encoding localparams ST_ACCUM=1'b0, ST_DONE=1'b1.
  - Saturation bound constants.
- One natural sub-module: booth_sat_add.
  - Combinational signed saturating adder.
  - Inputs: acc, sign-extended product.
  - Outputs: sum, sat flag.
  - Instanced once.
- FSM, counter and output registers stay in booth_mac_accum.

Test Plan:
- Reset: assert rst mid-group after products 10,20 → out_valid=0, in_ready=1; then products 5,in_last → out_acc=5, out_cnt=1, out_ovf=0.
- Basic group: products 6, -15, 64 with last on third, out_ready=1 → out_valid one cycle after third handshake; out_acc=55, out_cnt=3, out_ovf=0.
- Forced close: 16 products of 1, in_last never set → out_valid after 16th; out_acc=16, out_cnt=16; 17th product stalls (in_ready=0) until out_ready.
- Saturation: 9 products of 64 with last on ninth → out_acc=511, out_ovf=1. Then 10 products of -56 with last → out_acc=-512, out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 → outputs stable, in_ready=0, no product consumed. out_ready=1 → ACCUM next cycle, acc=0.
- Clear collision: clear=1 in the same cycle as handshake of product 30 after prior 12 → next cycle acc=0, cnt=0; following product 7 with last → out_acc=7, out_cnt=1.

Source files
------------

// File: rtl/booth_mac_accum_pkg.sv
// Shared widths, state encoding and saturation bounds for the Booth product
// accumulator stage.
package booth_mac_accum_pkg;

    localparam int PROD_W    = 8;
    localparam int ACC_W     = 10;
    localparam int MAX_TERMS = 16;
    localparam int CNT_W     = 5;

    localparam logic ST_ACCUM = 1'b0;
    localparam logic ST_DONE  = 1'b1;

    typedef enum logic {
        S_ACCUM = ST_ACCUM,
        S_DONE  = ST_DONE
    } state_e;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/booth_mac_accum_if.sv
// Product-in / group-result-out handshake bundle between the multiplier,
// the accumulator stage and the result consumer.
interface booth_mac_accum_if;
    import booth_mac_accum_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic [CNT_W-1:0]  out_cnt;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

endinterface

// File: rtl/booth_mac_accum_sat_add.sv
// Combinational signed saturating adder: one guard bit catches overflow,
// which then clamps the sum to the nearest representable bound.
module booth_sat_add
    import booth_mac_accum_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] addend_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             sat_o
);

    logic [ACC_W:0] wide;

    assign wide = {acc_i[ACC_W-1], acc_i} + {addend_i[ACC_W-1], addend_i};

    always_comb begin
        sum_o = wide[ACC_W-1:0];
        sat_o = 1'b0;
        // Top two bits disagree exactly when the true sum leaves the ACC_W range.
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            sat_o = 1'b1;
            sum_o = wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates Booth products into a saturating group sum and presents each
// closed group (explicit last or MAX_TERMS products) on a registered output.
module booth_mac_accum
    import booth_mac_accum_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    booth_mac_accum_if.slave bus
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] out_acc_q, out_acc_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             sat;
    logic             hs;
    logic             close;
    logic [CNT_W-1:0] cnt_inc;

    assign prod_ext = sext_prod(bus.in_prod);
    assign hs       = bus.in_valid && (state_q == S_ACCUM);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign close    = hs && (bus.in_last || (cnt_q == CNT_W'(MAX_TERMS - 1)));

    booth_sat_add u_sat_add (
        .acc_i    (acc_q),
        .addend_i (prod_ext),
        .sum_o    (sum),
        .sat_o    (sat)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        out_acc_d = out_acc_q;
        out_cnt_d = out_cnt_q;
        out_ovf_d = out_ovf_q;

        case (state_q)
            S_ACCUM: begin
                if (hs) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sat;
                    if (close) begin
                        state_d   = S_DONE;
                        out_acc_d = sum;
                        out_cnt_d = cnt_inc;
                        out_ovf_d = ovf_q | sat;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_ACCUM;
        endcase

        // Abort wins over both an accepted product and a result handoff.
        if (clear) begin
            state_d = S_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            out_acc_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            out_acc_q <= out_acc_d;
            out_cnt_q <= out_cnt_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ACCUM);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_acc   = out_acc_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule
